// File: rtl/mem_flash_loader.sv
// Byte-stream boot loader: length-prefixed little-endian stream in, one flash write per 32-bit word.
// Optional trailing XOR checksum byte is enabled by defining FLASH_LOADER_CHECKSUM_EN.
module mem_flash_loader #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [7:0]        i_in_data,
    output logic              o_flash_en,
    output logic [ADDR_W-1:0] o_flash_addr,
    output logic [WIDTH-1:0]  o_flash_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // Largest accepted word count; one bit wider than the length field so 2**16 still fits.
    localparam logic [16:0] LenMax = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
`ifdef FLASH_LOADER_CHECKSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e              r_state;
    logic [7:0]          r_len_lo;
    logic [15:0]         r_words_left;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_byte_idx;
    logic [WIDTH-1:0]    r_word;
    logic                r_in_ready;
    logic                r_flash_en;
    logic [ADDR_W-1:0]   r_flash_addr;
    logic [WIDTH-1:0]    r_flash_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]          r_csum;
`endif

    logic                w_accept;
    logic [15:0]         w_len;
    logic                w_len_too_big;
    logic [WIDTH-1:0]    w_word;

    assign w_accept      = i_in_valid & r_in_ready;
    assign w_len         = {i_in_data, r_len_lo};
    assign w_len_too_big = {1'b0, w_len} > LenMax;

    // Word as it will be once the current (final) byte lands in the top lane.
    always_comb begin
        w_word                = r_word;
        w_word[WIDTH-1 -: 8]  = i_in_data;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_len_lo     <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_in_ready   <= 1'b0;
            r_flash_en   <= 1'b0;
            r_flash_addr <= '0;
            r_flash_data <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_flash_en <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (i_start) begin
                        r_state    <= StLenLo;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_addr     <= '0;
                        r_byte_idx <= '0;
`ifdef FLASH_LOADER_CHECKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                StLenLo: begin
                    if (w_accept) begin
                        r_len_lo <= i_in_data;
                        r_state  <= StLenHi;
                    end
                end
                StLenHi: begin
                    if (w_accept) begin
                        if (w_len == 16'd0) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                            r_state    <= StCsum;
`else
                            r_state    <= StDone;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else if (w_len_too_big) begin
                            // Reject without draining the rest of the stream.
                            r_state    <= StDone;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_err      <= 1'b1;
                        end else begin
                            r_words_left <= w_len;
                            r_state      <= StData;
                        end
                    end
                end
                StData: begin
                    if (w_accept) begin
                        r_word[{r_byte_idx, 3'b000} +: 8] <= i_in_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef FLASH_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_in_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_state      <= StWrite;
                            r_in_ready   <= 1'b0;
                            r_flash_en   <= 1'b1;
                            r_flash_addr <= r_addr;
                            r_flash_data <= w_word;
                        end
                    end
                end
                StWrite: begin
                    r_addr       <= r_addr + 1'b1;
                    r_words_left <= r_words_left - 16'd1;
                    if (r_words_left == 16'd1) begin
`ifdef FLASH_LOADER_CHECKSUM_EN
                        r_state    <= StCsum;
                        r_in_ready <= 1'b1;
`else
                        r_state    <= StDone;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
`endif
                    end else begin
                        r_state    <= StData;
                        r_in_ready <= 1'b1;
                    end
                end
`ifdef FLASH_LOADER_CHECKSUM_EN
                StCsum: begin
                    if (w_accept) begin
                        if (i_in_data != r_csum) begin
                            r_err <= 1'b1;
                        end
                        r_state    <= StDone;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state    <= StIdle;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_flash_en   = r_flash_en;
    assign o_flash_addr = r_flash_addr;
    assign o_flash_data = r_flash_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;

    a_flash_one_cycle : assert property (@(posedge i_clk) disable iff (!i_rst)
        r_flash_en |=> !r_flash_en);
    a_no_ready_in_write : assert property (@(posedge i_clk) disable iff (!i_rst)
        r_flash_en |-> !r_in_ready);
    a_done_not_busy : assert property (@(posedge i_clk) disable iff (!i_rst)
        r_done |-> !r_busy);

endmodule

// File: tb/tb_mem_flash_loader.sv
// Self-checking bench for mem_flash_loader: table-driven loads, hand-written corner sequences,
// and randomized loads compared against a stream-level reference model.
module tb_mem_flash_loader;

    localparam int unsigned AddrW = 11;
    localparam int          Cap   = 2 ** AddrW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             flash_en;
    logic [AddrW-1:0] flash_addr;
    logic [31:0]      flash_data;
    logic             busy;
    logic             done;
    logic             err;

    mem_flash_loader #(
        .WIDTH  (32),
        .ADDR_W (AddrW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_flash_en   (flash_en),
        .o_flash_addr (flash_addr),
        .o_flash_data (flash_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] stream[$];
    logic [42:0] obs_q[$];
    logic [42:0] exp_q[$];
    logic       exp_err;
    logic       prev_en = 1'b0;

    typedef struct {
        int   n;
        int   pattern;
        int   gap;
        logic err;
        int   writes;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (flash_en) begin
            obs_q.push_back({flash_addr, flash_data});
            check("ready_low_in_write", {63'd0, in_ready}, 64'd0);
            check("flash_en_one_cycle", {63'd0, prev_en}, 64'd0);
        end
        prev_en = flash_en;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected writes and err derived directly from the byte stream.
    task automatic model();
        int         n;
        logic [7:0] x;
        exp_q.delete();
        n = int'({stream[1], stream[0]});
        exp_err = 1'b0;
        if (n > Cap) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({11'(i), stream[2+4*i+3], stream[2+4*i+2],
                             stream[2+4*i+1], stream[2+4*i]});
        end
        for (int j = 2; j < 2 + 4 * n; j++) x = x ^ stream[j];
`ifdef FLASH_LOADER_CHECKSUM_EN
        exp_err = (stream[2+4*n] != x);
`endif
    endtask

    task automatic build(input int n, input int pattern, input bit good);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h00;
        stream.delete();
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
        if (n <= Cap) begin
            for (int k = 0; k < 4 * n; k++) begin
                b = (pattern != 0) ? k[7:0] : 8'($urandom);
                x = x ^ b;
                stream.push_back(b);
            end
`ifdef FLASH_LOADER_CHECKSUM_EN
            stream.push_back(good ? x : ~x);
`endif
        end else begin
            for (int k = 0; k < 4; k++) stream.push_back(8'($urandom));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        bit sent;
        guard = 0;
        sent  = 1'b0;
        while (!sent) begin
            @(negedge clk);
            if (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = b;
                if (in_ready) sent = 1'b1;
            end
            guard++;
            if (!sent && guard > 500) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", b);
                break;
            end
        end
    endtask

    task automatic end_stream();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) send_byte(stream[i], gap);
    endtask

    function automatic int consumed();
        int n;
        n = int'({stream[1], stream[0]});
        return (n > Cap) ? 2 : stream.size();
    endfunction

    task automatic pulse_start(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        obs_q.delete();
        check({name, "_busy_after_start"}, {63'd0, busy}, 64'd1);
        check({name, "_done_cleared"}, {63'd0, done}, 64'd0);
        check({name, "_err_cleared"}, {63'd0, err}, 64'd0);
    endtask

    task automatic finish_load(input string name);
        int k;
        k = 0;
        while (!done && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({name, "_done"}, {63'd0, done}, 64'd1);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_err"}, {63'd0, err}, {63'd0, exp_err});
        check({name, "_ready_idle"}, {63'd0, in_ready}, 64'd0);
        check({name, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (obs_q[i] !== exp_q[i]) check({name, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
            else n_tests++;
        end
    endtask

    task automatic run_load(input string name, input int gap);
        model();
        pulse_start(name);
        send_range(0, consumed(), gap);
        end_stream();
        finish_load(name);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_flash_en"}, {63'd0, flash_en}, 64'd0);
        check({name, "_flash_addr"}, 64'(flash_addr), 64'd0);
        check({name, "_flash_data"}, 64'(flash_data), 64'd0);
        check({name, "_busy"}, {63'd0, busy}, 64'd0);
        check({name, "_done"}, {63'd0, done}, 64'd0);
        check({name, "_err"}, {63'd0, err}, 64'd0);
        check({name, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    endtask

    task automatic load_test2();
        stream = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef FLASH_LOADER_CHECKSUM_EN
        stream.push_back(8'h2A);
`endif
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{n: 2,        pattern: 0, gap: 0,  err: 1'b0, writes: 2};
        vecs[1] = '{n: 1,        pattern: 0, gap: 25, err: 1'b0, writes: 1};
        vecs[2] = '{n: 7,        pattern: 0, gap: 50, err: 1'b0, writes: 7};
        vecs[3] = '{n: 0,        pattern: 0, gap: 0,  err: 1'b0, writes: 0};
        vecs[4] = '{n: 2048,     pattern: 1, gap: 0,  err: 1'b0, writes: 2048};
        vecs[5] = '{n: 2049,     pattern: 0, gap: 0,  err: 1'b1, writes: 0};
        vecs[6] = '{n: 16'hFFFF, pattern: 0, gap: 0,  err: 1'b1, writes: 0};
        vecs[7] = '{n: 256,      pattern: 0, gap: 10, err: 1'b0, writes: 256};

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Reset mid-stream, with a start pulse coincident with reset
        build(3, 0, 1'b1);
        pulse_start("mid");
        send_range(0, 8, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        obs_q.delete();
        repeat (6) @(negedge clk);
        check("start_during_reset_ignored", {63'd0, busy}, 64'd0);
        check("no_write_after_reset", 64'(obs_q.size()), 64'd0);

        // Reference two-word load
        load_test2();
        run_load("t2", 0);
        if (obs_q.size() == 2) begin
            check("t2_word0", 64'(obs_q[0]), 64'({11'd0, 32'h12345678}));
            check("t2_word1", 64'(obs_q[1]), 64'({11'd1, 32'hDEADBEEF}));
        end

        // Same load under backpressure
        for (int r = 0; r < 3; r++) begin
            load_test2();
            run_load("t3_gaps", 40);
        end

        // start pulsed mid-DATA is ignored
        load_test2();
        model();
        pulse_start("t5");
        send_range(0, 4, 0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t5_still_busy", {63'd0, busy}, 64'd1);
        check("t5_still_ready", {63'd0, in_ready}, 64'd1);
        send_range(4, stream.size(), 0);
        end_stream();
        finish_load("t5");

        // Zero length finishes right after the length handshake
        build(0, 0, 1'b1);
        model();
        pulse_start("n0");
        send_range(0, 2, 0);
        @(negedge clk);
        in_valid = 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
        check("n0_waits_csum", {63'd0, done}, 64'd0);
        send_byte(stream[2], 0);
        @(negedge clk);
        in_valid = 1'b0;
`endif
        check("n0_done_next", {63'd0, done}, 64'd1);
        finish_load("n0");

        // Table of loads
        for (int v = 0; v < 8; v++) begin
            build(vecs[v].n, vecs[v].pattern, 1'b1);
            model();
            pulse_start("tbl");
            send_range(0, consumed(), vecs[v].gap);
            end_stream();
            finish_load("tbl_model");
            check("tbl_err", {63'd0, err}, {63'd0, vecs[v].err});
            check("tbl_nwrites", 64'(obs_q.size()), 64'(vecs[v].writes));
            if (vecs[v].writes > 0 && obs_q.size() > 0)
                check("tbl_last_addr", 64'(obs_q[obs_q.size()-1][42:32]),
                      64'(vecs[v].writes - 1));
        end

        // Randomized loads
        for (int r = 0; r < 12; r++) begin
            int n;
            n = ($urandom_range(5) == 0) ? Cap + 1 + int'($urandom_range(100))
                                         : int'($urandom_range(12));
            build(n, 0, 1'b1);
            run_load("rand", int'($urandom_range(60)));
        end

`ifdef FLASH_LOADER_CHECKSUM_EN
        // Bad checksum still writes every word
        load_test2();
        stream[10] = 8'h00;
        run_load("bad_csum", 0);
        check("bad_csum_err", {63'd0, err}, 64'd1);
        check("bad_csum_writes", 64'(obs_q.size()), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
